// File: rtl/mprj_checkpoint_monitor.sv
// Watches a bit-field of the mprj_io bus for an ordered list of firmware checkpoint codes,
// with glitch filtering, out-of-order detection and a global cycle timeout.
module mprj_checkpoint_monitor #(
    parameter int unsigned IO_WIDTH       = 38,
    parameter int unsigned CHECK_LSB      = 16,
    parameter int unsigned CHECK_WIDTH    = 16,
    parameter int unsigned PREFIX_WIDTH   = 8,
    parameter int unsigned NUM_STEPS      = 2,
    parameter int unsigned STABLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 70000
) (
    input  logic                                    wb_clk_i,
    input  logic                                    wb_rst_i,
    input  logic                                    start_i,
    input  logic [IO_WIDTH-1:0]                     io_in,
    input  logic [NUM_STEPS*CHECK_WIDTH-1:0]        exp_codes_i,
    output logic                                    busy_o,
    output logic                                    pass_o,
    output logic                                    fail_o,
    output logic                                    timeout_o,
    output logic [$clog2(NUM_STEPS+1)-1:0]          step_o,
    output logic [CHECK_WIDTH-1:0]                  last_code_o,
    output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]     cycle_cnt_o
);

    localparam int unsigned STEP_W = $clog2(NUM_STEPS + 1);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CHECK_WIDTH-1:0]  smp_q;
    logic [STAB_W-1:0]       stab_q;
    logic                    acted_q;

    logic [CHECK_WIDTH-1:0]  fld_c;
    logic [CHECK_WIDTH-1:0]  exp_cur_c;
    logic [CHECK_WIDTH-1:0]  exp_prev_c;
    logic                    stable_c;
    logic                    act_c;
    logic                    match_c;
    logic                    final_c;
    logic                    prefix_hit_c;
    logic                    fail_hit_c;
    logic                    tmo_hit_c;
    logic                    arm_c;
    logic                    unused_io;

    assign unused_io = ^io_in;

    // Field extraction and step-indexed lookup of the current / previous expected code
    always_comb begin
        fld_c      = io_in[CHECK_LSB +: CHECK_WIDTH];
        exp_cur_c  = '0;
        exp_prev_c = '0;
        for (int unsigned k = 0; k < NUM_STEPS; k++) begin
            if (step_o == STEP_W'(k)) begin
                exp_cur_c = exp_codes_i[k*CHECK_WIDTH +: CHECK_WIDTH];
            end
            if (step_o == STEP_W'(k + 1)) begin
                exp_prev_c = exp_codes_i[k*CHECK_WIDTH +: CHECK_WIDTH];
            end
        end
    end

    // A stable value is acted on once; a repeat of the code just matched is not out-of-order
    assign stable_c     = (stab_q == STAB_W'(STABLE_CYCLES));
    assign act_c        = (state_q == S_WAIT) && stable_c && !acted_q;
    assign match_c      = act_c && (smp_q == exp_cur_c);
    assign final_c      = (step_o == STEP_W'(NUM_STEPS - 1));
    assign prefix_hit_c = (smp_q[CHECK_WIDTH-1 -: PREFIX_WIDTH] ==
                           exp_cur_c[CHECK_WIDTH-1 -: PREFIX_WIDTH]);
    assign fail_hit_c   = act_c && !match_c && prefix_hit_c &&
                          ((step_o == '0) || (smp_q != exp_prev_c));
    assign tmo_hit_c    = (cycle_cnt_o == CNT_W'(TIMEOUT_CYCLES - 1));
    assign arm_c        = start_i && (state_q != S_WAIT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; PASS outranks FAIL outranks TIMEOUT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (match_c && final_c) begin
                    state_d = S_PASS;
                end else if (fail_hit_c) begin
                    state_d = S_FAIL;
                end else if (tmo_hit_c) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                if (start_i) begin
                    state_d = S_WAIT;
                end
            end
        endcase
    end

    // Sampling and stability tracking; arming restarts the stability count
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            smp_q   <= '0;
            stab_q  <= '0;
            acted_q <= 1'b0;
        end else begin
            smp_q <= fld_c;
            if (arm_c) begin
                stab_q  <= '0;
                acted_q <= 1'b0;
            end else if (fld_c == smp_q) begin
                if (!stable_c) begin
                    stab_q <= stab_q + STAB_W'(1);
                end
                if (stable_c) begin
                    acted_q <= 1'b1;
                end
            end else begin
                stab_q  <= STAB_W'(1);
                acted_q <= 1'b0;
            end
        end
    end

    // Registered status outputs and progress counters
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            busy_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            timeout_o   <= 1'b0;
            step_o      <= '0;
            last_code_o <= '0;
            cycle_cnt_o <= '0;
        end else begin
            busy_o    <= (state_d == S_WAIT);
            pass_o    <= (state_d == S_PASS);
            fail_o    <= (state_d == S_FAIL);
            timeout_o <= (state_d == S_TIMEOUT);
            if (arm_c) begin
                step_o      <= '0;
                cycle_cnt_o <= '0;
            end else if (state_q == S_WAIT) begin
                cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
                if (act_c) begin
                    last_code_o <= smp_q;
                end
                if (match_c) begin
                    step_o <= step_o + STEP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Randomized and directed bench for mprj_checkpoint_monitor against a sample-history reference model.
module tb_mprj_checkpoint_monitor;

    localparam int unsigned IO_W = 38;
    localparam int unsigned LSB  = 16;
    localparam int unsigned CW   = 16;
    localparam int unsigned NS   = 2;
    localparam int unsigned STAB = 2;
    localparam int unsigned TMO  = 100;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;
    localparam int M_TMO  = 4;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i;
    logic                start_i;
    logic [IO_W-1:0]     io_in;
    logic [NS*CW-1:0]    exp_codes_i;
    logic                busy_o;
    logic                pass_o;
    logic                fail_o;
    logic                timeout_o;
    logic [1:0]          step_o;
    logic [CW-1:0]       last_code_o;
    logic [6:0]          cycle_cnt_o;

    always #5 wb_clk_i = ~wb_clk_i;

    mprj_checkpoint_monitor #(
        .IO_WIDTH       (IO_W),
        .CHECK_LSB      (LSB),
        .CHECK_WIDTH    (CW),
        .PREFIX_WIDTH   (8),
        .NUM_STEPS      (NS),
        .STABLE_CYCLES  (STAB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .start_i     (start_i),
        .io_in       (io_in),
        .exp_codes_i (exp_codes_i),
        .busy_o      (busy_o),
        .pass_o      (pass_o),
        .fail_o      (fail_o),
        .timeout_o   (timeout_o),
        .step_o      (step_o),
        .last_code_o (last_code_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    int            m_state = M_IDLE;
    int            m_step  = 0;
    int            m_cnt   = 0;
    logic [CW-1:0] m_last  = '0;
    logic [CW-1:0] m_exp [NS];
    logic [CW-1:0] hist [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Length of the trailing run of identical samples seen since the monitor was armed
    function automatic int run_len();
        int n;
        int len;
        n   = hist.size();
        len = 0;
        if (n == 0) return 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (hist[i] != hist[n-1]) break;
            len++;
        end
        return len;
    endfunction

    // Reference model: what one clock edge does to the checkpoint sequence
    task automatic model_edge(input bit rst, input bit st, input logic [CW-1:0] f);
        bit            act;
        bit            done;
        bit            rep_prev;
        logic [CW-1:0] v;
        int            cnt_before;
        act  = 1'b0;
        done = 1'b0;
        v    = '0;
        if (rst) begin
            m_state = M_IDLE;
            m_step  = 0;
            m_cnt   = 0;
            m_last  = '0;
            hist.delete();
        end else if (m_state == M_WAIT) begin
            if (run_len() == int'(STAB)) begin
                act = 1'b1;
                v   = hist[hist.size()-1];
            end
            cnt_before = m_cnt;
            m_cnt++;
            if (act) begin
                m_last = v;
                rep_prev = (m_step > 0) ? (v == m_exp[m_step-1]) : 1'b0;
                if (v == m_exp[m_step]) begin
                    m_step++;
                    if (m_step == int'(NS)) begin
                        m_state = M_PASS;
                        done    = 1'b1;
                    end
                end else if (v[15:8] == m_exp[m_step][15:8] && !rep_prev) begin
                    m_state = M_FAIL;
                    done    = 1'b1;
                end
            end
            if (!done && cnt_before == int'(TMO) - 1) m_state = M_TMO;
            hist.push_back(f);
        end else if (st) begin
            m_state = M_WAIT;
            m_step  = 0;
            m_cnt   = 0;
            hist.delete();
        end
    endtask

    task automatic compare_all();
        check("busy",    32'(busy_o),      32'(m_state == M_WAIT));
        check("pass",    32'(pass_o),      32'(m_state == M_PASS));
        check("fail",    32'(fail_o),      32'(m_state == M_FAIL));
        check("timeout", 32'(timeout_o),   32'(m_state == M_TMO));
        check("step",    32'(step_o),      32'(m_step));
        check("last",    32'(last_code_o), 32'(m_last));
        check("cnt",     32'(cycle_cnt_o), 32'(m_cnt));
    endtask

    task automatic tick(input bit rst, input bit st, input logic [CW-1:0] f);
        wb_rst_i    = rst;
        start_i     = st;
        io_in       = IO_W'({$urandom, $urandom});
        io_in[LSB +: CW] = f;
        exp_codes_i = {m_exp[1], m_exp[0]};
        @(posedge wb_clk_i);
        model_edge(rst, st, f);
        #1;
        compare_all();
        start_i  = 1'b0;
        wb_rst_i = 1'b0;
    endtask

    function automatic logic [CW-1:0] pick_code();
        case ($urandom_range(0, 5))
            0:       return m_exp[0];
            1:       return m_exp[1];
            2:       return {m_exp[0][15:8], 8'($urandom)};
            3:       return {m_exp[1][15:8], 8'($urandom)};
            4:       return '0;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int nc;
        logic [CW-1:0] v;
        int hold;
        m_exp[0] = 16'hAB60;
        m_exp[1] = 16'hAB61;
        wb_rst_i = 1'b1;
        start_i  = 1'b0;
        io_in    = '0;
        exp_codes_i = {m_exp[1], m_exp[0]};

        tick(1, 0, 0);
        tick(1, 0, 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_step", 32'(step_o), 0);
        check("rst_cnt",  32'(cycle_cnt_o), 0);

        // Ordered pass with latency probe
        tick(0, 1, 0);
        repeat (3) tick(0, 0, 0);
        tick(0, 0, 16'hAB60);
        tick(0, 0, 16'hAB60);
        check("lat_pre", 32'(step_o), 0);
        tick(0, 0, 16'hAB60);
        check("lat_step1", 32'(step_o), 1);
        repeat (2) tick(0, 0, 16'hAB60);
        repeat (3) tick(0, 0, 16'hAB61);
        check("pass_flag", 32'(pass_o), 1);
        check("pass_busy", 32'(busy_o), 0);
        check("pass_step", 32'(step_o), 2);
        check("pass_last", 32'(last_code_o), 32'h0000AB61);
        repeat (3) tick(0, 0, 16'h5555);
        check("pass_frozen", 32'(last_code_o), 32'h0000AB61);

        // Glitch rejection, then out-of-order detection
        tick(0, 1, 0);
        repeat (3) tick(0, 0, 0);
        tick(0, 0, 16'hAB60);
        repeat (4) tick(0, 0, 0);
        check("glitch_step", 32'(step_o), 0);
        check("glitch_busy", 32'(busy_o), 1);
        repeat (3) tick(0, 0, 16'hAB60);
        check("glitch_step1", 32'(step_o), 1);
        repeat (4) tick(0, 0, 16'h1234);
        check("other_busy", 32'(busy_o), 1);
        check("other_last", 32'(last_code_o), 32'h00001234);
        repeat (3) tick(0, 0, 16'hAB60);
        check("repeat_busy", 32'(busy_o), 1);
        repeat (2) tick(0, 0, 16'hAB62);
        tick(0, 0, 0);
        check("ooo_fail", 32'(fail_o), 1);
        check("ooo_step", 32'(step_o), 1);
        check("ooo_last", 32'(last_code_o), 32'h0000AB62);

        // Timeout with the field idle
        tick(0, 1, 0);
        nc = 0;
        while (busy_o && nc < 200) begin
            tick(0, 0, 0);
            nc++;
        end
        check("tmo_flag", 32'(timeout_o), 1);
        check("tmo_cnt",  32'(cycle_cnt_o), TMO);
        check("tmo_pass", 32'(pass_o), 0);
        check("tmo_fail", 32'(fail_o), 0);

        // Final code lands on the timeout edge: pass wins
        tick(0, 1, 0);
        for (int k = 1; k <= 100; k++) begin
            tick(0, 0, (k <= 5) ? 16'hAB60 : ((k < 98) ? 16'h0000 : 16'hAB61));
        end
        check("tie_pass", 32'(pass_o), 1);
        check("tie_tmo",  32'(timeout_o), 0);
        check("tie_cnt",  32'(cycle_cnt_o), TMO);

        // One edge too late: timeout wins
        tick(0, 1, 0);
        for (int k = 1; k <= 100; k++) begin
            tick(0, 0, (k <= 5) ? 16'hAB60 : ((k < 99) ? 16'h0000 : 16'hAB61));
        end
        check("late_tmo",  32'(timeout_o), 1);
        check("late_pass", 32'(pass_o), 0);
        check("late_step", 32'(step_o), 1);

        // Reset mid-sequence, restart, ignored re-start
        tick(0, 1, 0);
        repeat (2) tick(0, 0, 0);
        repeat (3) tick(0, 0, 16'hAB60);
        check("mid_step", 32'(step_o), 1);
        tick(1, 0, 16'hAB60);
        check("mid_rst_step", 32'(step_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_last", 32'(last_code_o), 0);
        tick(0, 0, 0);
        tick(0, 1, 16'hAB60);
        repeat (3) tick(0, 0, 16'hAB60);
        tick(0, 1, 16'hAB60);
        check("restart_ignored", 32'(step_o), 1);
        repeat (3) tick(0, 0, 16'hAB61);
        check("restart_pass", 32'(pass_o), 1);

        // Randomized episodes against the model
        for (int ep = 0; ep < 40; ep++) begin
            if ($urandom_range(0, 1) == 1) begin
                m_exp[0] = 16'($urandom);
                m_exp[1] = ($urandom_range(0, 1) == 1) ? {m_exp[0][15:8], 8'($urandom)}
                                                       : 16'($urandom);
            end
            tick(0, 1, pick_code());
            nc = 0;
            while (nc < 150 && m_state == M_WAIT) begin
                v    = pick_code();
                hold = int'($urandom_range(1, 4));
                for (int h = 0; h < hold; h++) begin
                    tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0), v);
                end
                nc += hold;
            end
            repeat (2) tick(0, 0, pick_code());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
